// File: rtl/game_round_if.sv
// Bus between the round controller and the surrounding game stages.
// The master side drives the button pulses and score; the slave side is the controller.
interface game_round_if #(
    parameter int SCORE_W = 12
);
    logic               start;
    logic               lvl_easy;
    logic               lvl_med;
    logic               lvl_hard;
    logic [SCORE_W-1:0] score;
    logic [1:0]         level;
    logic               game_active;
    logic               game_clr;
    logic [1:0]         state;
    logic [6:0]         time_left;
    logic [SCORE_W-1:0] high_score;
    logic               new_high;

    modport master (
        output start, lvl_easy, lvl_med, lvl_hard, score,
        input  level, game_active, game_clr, state, time_left, high_score, new_high
    );

    modport slave (
        input  start, lvl_easy, lvl_med, lvl_hard, score,
        output level, game_active, game_clr, state, time_left, high_score, new_high
    );
endinterface

// File: rtl/game_round_ctrl.sv
// Whack-a-mole round controller: level select, countdown, timed play window, high score.
// Optional macro GAME_ROUND_ABORT_EN: start during COUNTDOWN/PLAY aborts the round to IDLE.
module game_round_ctrl #(
    parameter int CLK_HZ            = 50000000,
    parameter int COUNTDOWN_SECONDS = 3,
    parameter int GAME_SECONDS      = 30,
    parameter int SCORE_W           = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    game_round_if.slave bus
);
    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);
    localparam logic [6:0] CD_INIT   = 7'(COUNTDOWN_SECONDS);
    localparam logic [6:0] GAME_INIT = 7'(GAME_SECONDS);
`ifdef GAME_ROUND_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COUNTDOWN = 2'd1,
        S_PLAY      = 2'd2,
        S_OVER      = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [6:0]         time_q, time_d;
    logic [1:0]         level_q, level_d;
    logic               clr_q, clr_d;
    logic               active_q, active_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic               new_high_q, new_high_d;
    logic               timing;
    logic               sec_tick;

    // Priority easy > med > hard; no pulse keeps the current level.
    function automatic logic [1:0] pick_level(input logic easy, input logic med,
                                              input logic hard, input logic [1:0] cur);
        if (easy)      return 2'd0;
        else if (med)  return 2'd1;
        else if (hard) return 2'd2;
        else           return cur;
    endfunction

    function automatic logic beats(input logic [SCORE_W-1:0] s, input logic [SCORE_W-1:0] best);
        return s > best;
    endfunction

    assign timing   = (state_q == S_COUNTDOWN) || (state_q == S_PLAY);
    assign sec_tick = timing && (cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            time_q     <= '0;
            level_q    <= 2'd0;
            clr_q      <= 1'b0;
            active_q   <= 1'b0;
            high_q     <= '0;
            new_high_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            time_q     <= time_d;
            level_q    <= level_d;
            clr_q      <= clr_d;
            active_q   <= active_d;
            high_q     <= high_d;
            new_high_q <= new_high_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        time_d     = time_q;
        level_d    = level_q;
        clr_d      = 1'b0;
        high_d     = high_q;
        new_high_d = new_high_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                level_d = pick_level(bus.lvl_easy, bus.lvl_med, bus.lvl_hard, level_q);
                if (bus.start) begin
                    state_d    = S_COUNTDOWN;
                    time_d     = CD_INIT;
                    clr_d      = 1'b1;
                    new_high_d = 1'b0;
                end
            end
            S_COUNTDOWN, S_PLAY: begin
                if (ABORT_EN && bus.start) begin
                    state_d = S_IDLE;
                    time_d  = '0;
                end else if (sec_tick) begin
                    // Counter wraps to 0 on the tick, so a phase change also restarts it.
                    if (time_q == 7'd1) begin
                        if (state_q == S_COUNTDOWN) begin
                            state_d = S_PLAY;
                            time_d  = GAME_INIT;
                        end else begin
                            state_d = S_OVER;
                            time_d  = '0;
                            if (beats(bus.score, high_q)) begin
                                high_d     = bus.score;
                                new_high_d = 1'b1;
                            end
                        end
                    end else begin
                        time_d = time_q - 7'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        active_d = (state_d == S_PLAY);
    end

    assign bus.state       = state_q;
    assign bus.level       = level_q;
    assign bus.time_left   = time_q;
    assign bus.game_clr    = clr_q;
    assign bus.game_active = active_q;
    assign bus.high_score  = high_q;
    assign bus.new_high    = new_high_q;
endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl: level-select vector table plus full-round sequences.
module tb_game_round_ctrl;
    localparam int CLK_HZ = 10;
    localparam int CD_S   = 3;
    localparam int GAME_S = 5;
    localparam int SW     = 12;

    logic CLOCK_50 = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    game_round_if #(.SCORE_W(SW)) bus ();

    game_round_ctrl #(
        .CLK_HZ(CLK_HZ), .COUNTDOWN_SECONDS(CD_S), .GAME_SECONDS(GAME_S), .SCORE_W(SW)
    ) dut (
        .clk(CLOCK_50), .rst_n(rst_n), .bus(bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic       e;
        logic       m;
        logic       h;
        logic [1:0] lvl;
    } lvec_t;

    lvec_t tbl [8];

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {state, time_left, game_active, game_clr, new_high}
    function automatic logic [31:0] obs();
        return 32'({bus.state, bus.time_left, bus.game_active, bus.game_clr, bus.new_high});
    endfunction

    function automatic logic [31:0] ev(input logic [1:0] st, input logic [6:0] tl,
                                       input logic act, input logic clr, input logic nh);
        return 32'({st, tl, act, clr, nh});
    endfunction

    task automatic run_round(input string tag, input logic [SW-1:0] sc,
                             input logic [SW-1:0] exp_high, input logic exp_new,
                             input logic with_easy, input int med_at,
                             input int abort_at, input int rst_at);
        logic [1:0] lvl0;
        lvl0 = with_easy ? 2'd0 : bus.level;
        bus.score    = sc;
        bus.start    = 1'b1;
        bus.lvl_easy = with_easy;
        tick();
        bus.start    = 1'b0;
        bus.lvl_easy = 1'b0;
        chk({tag, " level at start"}, 32'(bus.level), 32'(lvl0));
        for (int k = 0; k < CD_S * CLK_HZ; k++) begin
            chk({tag, " countdown"}, obs(), ev(2'd1, 7'(CD_S - k / CLK_HZ), 1'b0, k == 0, 1'b0));
            tick();
        end
        for (int k = 0; k < GAME_S * CLK_HZ; k++) begin
            chk({tag, " play"}, obs(), ev(2'd2, 7'(GAME_S - k / CLK_HZ), 1'b1, 1'b0, 1'b0));
            if (k == rst_at) begin
                rst_n = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
                chk({tag, " reset state"}, obs(), ev(2'd0, 7'd0, 1'b0, 1'b0, 1'b0));
                chk({tag, " reset high"}, 32'(bus.high_score), 32'd0);
                chk({tag, " reset level"}, 32'(bus.level), 32'd0);
                return;
            end
            if (k == med_at) begin
                bus.lvl_med = 1'b1;
                tick();
                bus.lvl_med = 1'b0;
                chk({tag, " level in play"}, 32'(bus.level), 32'(lvl0));
                continue;
            end
            if (k == abort_at) begin
                bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
`ifdef GAME_ROUND_ABORT_EN
                chk({tag, " abort"}, obs(), ev(2'd0, 7'd0, 1'b0, 1'b0, 1'b0));
                tick();
                chk({tag, " abort no clr"}, obs(), ev(2'd0, 7'd0, 1'b0, 1'b0, 1'b0));
                chk({tag, " abort high"}, 32'(bus.high_score), 32'(exp_high));
                return;
`else
                continue;
`endif
            end
            tick();
        end
        chk({tag, " over"}, obs(), ev(2'd3, 7'd0, 1'b0, 1'b0, exp_new));
        chk({tag, " high"}, 32'(bus.high_score), 32'(exp_high));
        chk({tag, " level kept"}, 32'(bus.level), 32'(lvl0));
    endtask

    initial begin
        tbl[0] = '{e: 1'b0, m: 1'b0, h: 1'b1, lvl: 2'd2};
        tbl[1] = '{e: 1'b0, m: 1'b0, h: 1'b0, lvl: 2'd2};
        tbl[2] = '{e: 1'b0, m: 1'b1, h: 1'b0, lvl: 2'd1};
        tbl[3] = '{e: 1'b1, m: 1'b0, h: 1'b1, lvl: 2'd0};
        tbl[4] = '{e: 1'b0, m: 1'b1, h: 1'b1, lvl: 2'd1};
        tbl[5] = '{e: 1'b1, m: 1'b1, h: 1'b1, lvl: 2'd0};
        tbl[6] = '{e: 1'b0, m: 1'b0, h: 1'b1, lvl: 2'd2};
        tbl[7] = '{e: 1'b0, m: 1'b0, h: 1'b0, lvl: 2'd2};

        rst_n        = 1'b0;
        bus.start    = 1'b1;
        bus.lvl_easy = 1'b0;
        bus.lvl_med  = 1'b0;
        bus.lvl_hard = 1'b1;
        bus.score    = 12'd5;
        tick();
        tick();
        rst_n        = 1'b1;
        bus.start    = 1'b0;
        bus.lvl_hard = 1'b0;
        chk("reset outputs", obs(), ev(2'd0, 7'd0, 1'b0, 1'b0, 1'b0));
        chk("reset level", 32'(bus.level), 32'd0);
        chk("reset high", 32'(bus.high_score), 32'd0);

        for (int i = 0; i < 8; i++) begin
            bus.lvl_easy = tbl[i].e;
            bus.lvl_med  = tbl[i].m;
            bus.lvl_hard = tbl[i].h;
            tick();
            bus.lvl_easy = 1'b0;
            bus.lvl_med  = 1'b0;
            bus.lvl_hard = 1'b0;
            chk($sformatf("level vec %0d", i), 32'(bus.level), 32'(tbl[i].lvl));
            chk($sformatf("idle vec %0d", i), obs(), ev(2'd0, 7'd0, 1'b0, 1'b0, 1'b0));
        end

        run_round("r1", 12'd25, 12'd25, 1'b1, 1'b0, 15, -1, -1);
        for (int i = 0; i < 3; i++) tick();
        chk("over hold", obs(), ev(2'd3, 7'd0, 1'b0, 1'b0, 1'b1));
        chk("over hold high", 32'(bus.high_score), 32'd25);
        bus.lvl_med = 1'b1;
        tick();
        bus.lvl_med = 1'b0;
        chk("level in over", 32'(bus.level), 32'd1);

        run_round("r2 tie", 12'd25, 12'd25, 1'b0, 1'b0, -1, -1, -1);
        run_round("r3 new", 12'd40, 12'd40, 1'b1, 1'b1, -1, -1, -1);
        run_round("r4 start in play", 12'd10, 12'd40, 1'b0, 1'b0, -1, 25, -1);
        run_round("r5 reset in play", 12'd40, 12'd0, 1'b0, 1'b0, -1, -1, 20);
        run_round("r6 zero", 12'd0, 12'd0, 1'b0, 1'b0, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Round/session controller sitting directly upstream of the rng stage in the whack-a-mole game.
- Consumes debounced button pulses and selects the difficulty level. Runs a countdown, then a timed play window during which the rng and LED stages are enabled.
- At end of round, samples the running score from the LED/switch stage and maintains a high score for display.

Parameters:
- CLK_HZ, 50000000, clock cycles per second; sets the 1 s tick period.
- COUNTDOWN_SECONDS, 3, pre-round countdown length in seconds (1..127).
- GAME_SECONDS, 30, play window length in seconds (1..127).
- SCORE_W, 12, width of the score and high-score buses.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  debounced one-cycle pulse that starts a round.
- lvl_easy  in  1  debounced pulse; selects level 0.
- lvl_med  in  1  debounced pulse; selects level 1.
- lvl_hard  in  1  debounced pulse; selects level 2.
- score  in  SCORE_W  running score from the LED/switch stage.
- level  out  2  difficulty level to rng (0/1/2).
- game_active  out  1  high only in PLAY; enables rng and LED stages.
- game_clr  out  1  one-cycle pulse clearing the score and rng at round start.
- state  out  2  0=IDLE, 1=COUNTDOWN, 2=PLAY, 3=OVER.
- time_left  out  7  seconds remaining in the current phase.
- high_score  out  SCORE_W  best final score since reset.
- new_high  out  1  high when the last round set a new high score.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE; level=0; game_active=0; game_clr=0; time_left=0; high_score=0; new_high=0.
  - Tick counter is cleared.
  - Reset during any state, including PLAY, aborts the round and clears high_score.
- All outputs are registered. Any transition is visible on the cycle after the triggering edge.
- Tick generator:
  - Counter runs 0..CLK_HZ-1 in COUNTDOWN and PLAY only; sec_tick is high for one cycle at CLK_HZ-1.
  - Counter is forced to 0 on every state change and while in IDLE/OVER.
- Level select:
  - Accepted only in IDLE and OVER; ignored in COUNTDOWN and PLAY.
  - Simultaneous pulses resolve with priority easy > med > hard.
  - level holds its value when no pulse arrives. It never reverts to 0 except on reset or an easy pulse.
- IDLE or OVER, start=1:
  - Next state COUNTDOWN; time_left=COUNTDOWN_SECONDS; game_clr=1 for exactly that first COUNTDOWN cycle.
  - new_high is cleared.
  - If a level pulse arrives in the same cycle as start, the level is latched; the start still takes effect.
- COUNTDOWN:
  - Each sec_tick decrements time_left.
  - A sec_tick with time_left==1 moves to PLAY with time_left=GAME_SECONDS.
  - Total COUNTDOWN duration is exactly COUNTDOWN_SECONDS*CLK_HZ cycles.
- PLAY:
  - game_active=1. Each sec_tick decrements time_left.
  - A sec_tick with time_left==1 moves to OVER with time_left=0.
  - game_active is high for exactly GAME_SECONDS*CLK_HZ cycles.
- PLAY→OVER edge:
  - score is sampled on that same edge.
  - If score > high_score (strict, unsigned), high_score takes score and new_high=1. Otherwise both are unchanged and new_high stays 0.
- OVER:
  - game_active=0. Remains until start; high_score and new_high are held.
- start during COUNTDOWN or PLAY is ignored (see Optional Feature).
- Score ties never set new_high. A score of 0 never exceeds the reset high_score.

Optional Feature:
- Macro: GAME_ROUND_ABORT_EN.
- Defined: start during COUNTDOWN or PLAY returns to IDLE on the next cycle.
  - game_active=0; time_left=0.
  - high_score and new_high are unchanged; score is not sampled.
  - game_clr is not pulsed.
- Undefined: start is ignored in COUNTDOWN and PLAY.

Test Plan:
- Benches use CLK_HZ=10, COUNTDOWN_SECONDS=3, GAME_SECONDS=5.
1. Reset: rst_n low 2 cycles from arbitrary state → state=0, level=0, time_left=0, high_score=0, new_high=0, game_active=0.
2. Level select in IDLE:
   - lvl_hard pulse → level=2.
   - lvl_easy+lvl_hard together → level=0.
   - lvl_med pulse during PLAY → level unchanged.
3. Full round:
   - start → game_clr high exactly 1 cycle.
   - COUNTDOWN lasts 30 cycles with time_left 3,2,1.
   - PLAY lasts 50 cycles with time_left 5..1 and game_active high exactly 50 cycles.
   - Then OVER with time_left=0.
4. High score:
   - Round with score=25 at end → high_score=25, new_high=1.
   - Next round score=25 → high_score=25, new_high=0.
   - Next round score=40 → high_score=40, new_high=1.
5. Reset mid-operation: rst_n low at PLAY time_left=3 after high_score=40 → IDLE, game_active=0, high_score=0.
6. start during PLAY:
   - Without GAME_ROUND_ABORT_EN → round continues to full 50 cycles.
   - With the macro → IDLE next cycle, high_score unchanged, no game_clr pulse.
